sample_timing_sequencer: RTL

//  Programmable sample-rate timing generator for the sound path. Produces per-frame

---
 rtl/sound_timing_pkg.sv | 16 +
 rtl/sample_slot_decoder.sv | 23 ++
 rtl/sample_timing_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sound_timing_pkg.sv
// Shared definitions for the sound-path sample timing sequencer: FSM state encoding
// and the minimum-period helper that keeps every DAC slot inside the frame.
package sound_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Shortest period whose frame still contains the last slot's final cycle.
    function automatic int min_period(input int win_start, input int num_ch, input int slot_len);
        return win_start + num_ch * slot_len - 1;
    endfunction

endpackage

// File: rtl/sample_slot_decoder.sv
// Decodes the frame count into NUM_CH consecutive, non-overlapping DAC slots:
// active-low chip select across each window and a load strobe on its first cycle.
module sample_slot_decoder #(
    parameter int CNT_W     = 11,
    parameter int NUM_CH    = 2,
    parameter int WIN_START = 1070,
    parameter int SLOT_LEN  = 32
) (
    input  logic [CNT_W-1:0]  count,
    input  logic              running,
    output logic [NUM_CH-1:0] dac_cs,
    output logic [NUM_CH-1:0] dac_load
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        localparam logic [CNT_W-1:0] SLOT_LO = CNT_W'(WIN_START + k * SLOT_LEN);
        localparam logic [CNT_W-1:0] SLOT_HI = CNT_W'(WIN_START + (k + 1) * SLOT_LEN - 1);

        assign dac_cs[k]   = ~(running && (count >= SLOT_LO) && (count <= SLOT_HI));
        assign dac_load[k] = running && (count == SLOT_LO);
    end

endmodule

// File: rtl/sample_timing_sequencer.sv
// Programmable sample-rate frame generator: frame counter with shadowed period,
// run/drain FSM, sample request/ack handshake with underrun flag, and DAC slot timing.
module sample_timing_sequencer
    import sound_timing_pkg::*;
#(
    parameter int CNT_W          = 11,
    parameter int NUM_CH         = 2,
    parameter int WIN_START      = 1070,
    parameter int SLOT_LEN       = 32,
    parameter int DEFAULT_PERIOD = 1134
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  period_in,
    input  logic              period_wr,
    input  logic              sample_ack,
    output logic              sound_load,
    output logic              sample_req,
    output logic              underrun,
    output logic [NUM_CH-1:0] DAC_cs,
    output logic [NUM_CH-1:0] DAC_load,
    output logic              running
);

    localparam int               MIN_P      = min_period(WIN_START, NUM_CH, SLOT_LEN);
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(MIN_P);
    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);

    if (NUM_CH < 1 || MIN_P >= (1 << CNT_W) || DEFAULT_PERIOD < MIN_P
        || DEFAULT_PERIOD >= (1 << CNT_W)) begin : g_param_check
        $error("sample_timing_sequencer: slot windows or default period do not fit CNT_W");
    end

    seq_state_t       state_r, state_next;
    logic [CNT_W-1:0] count_r, count_next;
    logic [CNT_W-1:0] period_r, period_next;
    logic [CNT_W-1:0] pending_r, pending_next;
    logic             sample_req_r, sample_req_next;
    logic             wrap_s, running_s, sound_load_s;

    assign wrap_s       = (count_r == period_r);
    assign running_s    = (state_r != ST_IDLE);
    assign sound_load_s = (state_r == ST_RUN) && (count_r == '0);

    // Run/drain FSM; stopping on the wrap edge goes straight to IDLE so no empty drain frame.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_next = ST_RUN;
                else        state_next = ST_IDLE;
            end
            ST_RUN, ST_DRAIN: begin
                if (enable)      state_next = ST_RUN;
                else if (wrap_s) state_next = ST_IDLE;
                else             state_next = ST_DRAIN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter, period shadow and request handshake next-state.
    always_comb begin
        count_next      = count_r;
        period_next     = period_r;
        pending_next    = pending_r;
        sample_req_next = sample_req_r;

        if (!running_s || wrap_s) count_next = '0;
        else                      count_next = count_r + CNT_W'(1);

        if (period_wr) pending_next = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
        else           pending_next = pending_r;

        // Active period only changes at the wrap so a frame never sees two lengths.
        if (running_s && wrap_s) period_next = pending_r;
        else                     period_next = period_r;

        if (state_next == ST_IDLE) sample_req_next = 1'b0;
        else if (sound_load_s)     sample_req_next = 1'b1;
        else if (sample_ack)       sample_req_next = 1'b0;
        else                       sample_req_next = sample_req_r;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            period_r     <= DEF_PERIOD;
            pending_r    <= DEF_PERIOD;
            sample_req_r <= 1'b0;
        end else begin
            state_r      <= state_next;
            count_r      <= count_next;
            period_r     <= period_next;
            pending_r    <= pending_next;
            sample_req_r <= sample_req_next;
        end
    end

    assign sound_load = sound_load_s;
    assign sample_req = sample_req_r;
    assign underrun   = sound_load_s && sample_req_r;
    assign running    = running_s;

    sample_slot_decoder #(
        .CNT_W     (CNT_W),
        .NUM_CH    (NUM_CH),
        .WIN_START (WIN_START),
        .SLOT_LEN  (SLOT_LEN)
    ) u_slot_decoder (
        .count    (count_r),
        .running  (running_s),
        .dac_cs   (DAC_cs),
        .dac_load (DAC_load)
    );

endmodule
